// File: rtl/periph_bus_master.sv
// Load/store initiator for the memory-mapped peripheral bus: region/alignment checks, sub-word RMW stores, extended loads.
// Optional fault-address capture enabled by defining PERIPH_BUS_MASTER_ERR_CAPTURE_EN.
module periph_bus_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        per_wr_en_o,
    output logic [19:0] per_wr_addr_o,
    output logic [31:0] per_wr_data_o,
    output logic        per_rd_en_o,
    output logic [19:0] per_rd_addr_o,
    input  logic [31:0] per_rd_data_i
`ifdef PERIPH_BUS_MASTER_ERR_CAPTURE_EN
    ,
    output logic [31:0] err_addr_o,
    output logic        err_valid_o,
    input  logic        err_clr_i
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

    state_t      state_q;
    logic        ready_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        wr_en_q;
    logic [19:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        rd_en_q;
    logic [19:0] rd_addr_q;
    logic        req_fault_d;
    logic        accept_d;

    // Replace the addressed byte or halfword lane of the fetched word with the store data.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] off, input logic [1:0] size);
        logic [31:0] res;
        res = word;
        case (size)
            2'd0: res[{off, 3'b000} +: 8] = wdata[7:0];
            2'd1: res[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {off, 3'b000};
        case (size)
            2'd0: res = uns ? {24'h00_0000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'd1: res = uns ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    assign req_fault_d = (req_addr_i[31:20] != BASE_ADDR[31:20]) ||
                         (req_size_i == 2'd3) ||
                         ((req_size_i == 2'd1) && req_addr_i[0]) ||
                         ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'b00));
    assign accept_d = (state_q == S_IDLE) && req_valid_i;

    // Request sequencer; every bus and response output is a register updated here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            wdata_q     <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 20'h0_0000;
            wr_data_q   <= 32'h0000_0000;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= 20'h0_0000;
        end else begin
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        ready_q <= 1'b0;
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i;
                        size_q  <= req_size_i;
                        uns_q   <= req_unsigned_i;
                        wdata_q <= req_wdata_i;
                        if (req_fault_d) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0000_0000;
                        end else begin
                            state_q <= S_ACCESS;
                            // Word stores go straight out; loads and sub-word stores read first.
                            if (req_we_i && (req_size_i == 2'd2)) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= {req_addr_i[19:2], 2'b00};
                                wr_data_q <= req_wdata_i;
                            end else begin
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= {req_addr_i[19:2], 2'b00};
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (we_q && (size_q != 2'd2)) begin
                        state_q   <= S_WRITE;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {addr_q[19:2], 2'b00};
                        wr_data_q <= merge_store(per_rd_data_i, wdata_q, addr_q[1:0], size_q);
                    end else begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'h0000_0000
                                            : extract_load(per_rd_data_i, addr_q[1:0], size_q, uns_q);
                    end
                end
                S_WRITE: begin
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0000_0000;
                end
                S_RESP: begin
                    state_q   <= S_IDLE;
                    ready_q   <= 1'b1;
                    rsp_err_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o   = ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign per_wr_en_o   = wr_en_q;
    assign per_wr_addr_o = wr_addr_q;
    assign per_wr_data_o = wr_data_q;
    assign per_rd_en_o   = rd_en_q;
    assign per_rd_addr_o = rd_addr_q;

`ifdef PERIPH_BUS_MASTER_ERR_CAPTURE_EN
    logic [31:0] err_addr_q;
    logic        err_valid_q;

    // Sticky first-fault address; a fault coinciding with a clear is still captured.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_addr_q  <= 32'h0000_0000;
            err_valid_q <= 1'b0;
        end else if (accept_d && req_fault_d && (!err_valid_q || err_clr_i)) begin
            err_addr_q  <= req_addr_i;
            err_valid_q <= 1'b1;
        end else if (err_clr_i) begin
            err_valid_q <= 1'b0;
        end
    end

    assign err_addr_o  = err_addr_q;
    assign err_valid_o = err_valid_q;
`endif

endmodule

// File: tb/tb_periph_bus_master.sv
// Self-checking bench for periph_bus_master: directed plan cases plus randomized traffic against a byte-level memory model.
module tb_periph_bus_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [1:0]  req_size_i = 2'd0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        per_wr_en_o;
    logic [19:0] per_wr_addr_o;
    logic [31:0] per_wr_data_o;
    logic        per_rd_en_o;
    logic [19:0] per_rd_addr_o;
    logic [31:0] per_rd_data_i;
`ifdef PERIPH_BUS_MASTER_ERR_CAPTURE_EN
    logic [31:0] err_addr_o;
    logic        err_valid_o;
    logic        err_clr_i = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // Peripheral register file (64 words) and the bench's own byte-level reference memory.
    logic [31:0] pmem [0:63];
    logic [7:0]  ref_bytes [0:255];
    logic        bench_we = 1'b0;
    logic [5:0]  bench_idx = 6'd0;
    logic [31:0] bench_val = 32'h0;

    periph_bus_master dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .per_wr_en_o(per_wr_en_o), .per_wr_addr_o(per_wr_addr_o),
        .per_wr_data_o(per_wr_data_o), .per_rd_en_o(per_rd_en_o), .per_rd_addr_o(per_rd_addr_o),
        .per_rd_data_i(per_rd_data_i)
`ifdef PERIPH_BUS_MASTER_ERR_CAPTURE_EN
        , .err_addr_o(err_addr_o), .err_valid_o(err_valid_o), .err_clr_i(err_clr_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    assign per_rd_data_i = pmem[per_rd_addr_o[7:2]];

    always @(posedge clk_i) begin
        if (per_wr_en_o) pmem[per_wr_addr_o[7:2]] <= per_wr_data_o;
        else if (bench_we) pmem[bench_idx] <= bench_val;
    end

    task automatic set_word(input int idx, input logic [31:0] val);
        @(negedge clk_i);
        bench_we = 1'b1; bench_idx = idx[5:0]; bench_val = val;
        @(posedge clk_i); #1;
        bench_we = 1'b0;
        for (int b = 0; b < 4; b++) ref_bytes[idx*4 + b] = val[b*8 +: 8];
    endtask

    function automatic logic model_fault(input logic [31:0] addr, input logic [1:0] size);
        logic in_region;
        logic aligned;
        in_region = (addr - 32'h0200_0000) < 32'h0010_0000;
        aligned = (size != 2'd3) && ((addr % (32'd1 << size)) == 32'd0);
        return !(in_region && aligned);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        int n;
        longint v;
        n = 1 << size;
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(ref_bytes[(addr[7:0] + i) % 256]) << (8*i));
        if (!uns && n < 4 && ((v >> (8*n - 1)) & 1) == 1) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        for (int i = 0; i < (1 << size); i++) ref_bytes[addr[7:0] + i] = wdata[8*i +: 8];
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size, input logic uns,
                          input logic [31:0] wdata, output logic ready_seen, output int lat, output int rd_at,
                          output int wr_at, output logic [31:0] wr_data_seen, output logic [19:0] wr_addr_seen,
                          output logic [31:0] rdata, output logic err, output logic overlap);
        lat = 0; rd_at = 0; wr_at = 0; wr_data_seen = 32'h0; wr_addr_seen = 20'h0;
        rdata = 32'h0; err = 1'b0; overlap = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_size_i = size;
        req_unsigned_i = uns; req_wdata_i = wdata;
        ready_seen = req_ready_o;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk_i);
            if (per_rd_en_o) rd_at = n;
            if (per_wr_en_o) begin wr_at = n; wr_data_seen = per_wr_data_o; wr_addr_seen = per_wr_addr_o; end
            if (per_rd_en_o && per_wr_en_o) overlap = 1'b1;
            if (rsp_valid_o) begin lat = n; rdata = rsp_rdata_o; err = rsp_err_o; break; end
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, per_wr_en_o, per_rd_en_o} !== 5'b10000 ||
            rsp_rdata_o !== 32'h0 || per_wr_addr_o !== 20'h0 || per_rd_addr_o !== 20'h0 || per_wr_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b rsp=%b err=%b wr=%b rd=%b rdata=%h expected ready=1 rest 0",
                     req_ready_o, rsp_valid_o, rsp_err_o, per_wr_en_o, per_rd_en_o, rsp_rdata_o);
        end
`ifdef PERIPH_BUS_MASTER_ERR_CAPTURE_EN
        n_checks++;
        if (err_valid_o !== 1'b0 || err_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_err_capture: valid=%b addr=%h expected 0", err_valid_o, err_addr_o);
        end
`endif
        @(negedge clk_i); rst_i = 1'b0;
    endtask

    task automatic test_word_load();
        logic rdy, err, ov; int lat, rd_at, wr_at; logic [31:0] wd, rd; logic [19:0] wa;
        set_word(0, 32'h1234_5678);
        do_req(1'b0, 32'h0200_0000, 2'd2, 1'b0, 32'h0, rdy, lat, rd_at, wr_at, wd, wa, rd, err, ov);
        n_checks++;
        if (!rdy || rd_at != 1 || wr_at != 0 || lat != 2 || rd !== 32'h1234_5678 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL word_load: ready=%b rd_at=%0d wr_at=%0d lat=%0d rdata=%h err=%b expected 1,1,0,2,12345678,0",
                     rdy, rd_at, wr_at, lat, rd, err);
        end
    endtask

    task automatic test_byte_load();
        logic rdy, err, ov; int lat, rd_at, wr_at; logic [31:0] wd, rd; logic [19:0] wa;
        set_word(1, 32'h0000_8000);
        do_req(1'b0, 32'h0200_0005, 2'd0, 1'b0, 32'h0, rdy, lat, rd_at, wr_at, wd, wa, rd, err, ov);
        n_checks++;
        if (rd !== 32'hFFFF_FF80 || lat != 2 || err !== 1'b0) begin
            n_fail++; $display("FAIL lb_signed: rdata=%h lat=%0d err=%b expected ffffff80,2,0", rd, lat, err);
        end
        do_req(1'b0, 32'h0200_0005, 2'd0, 1'b1, 32'h0, rdy, lat, rd_at, wr_at, wd, wa, rd, err, ov);
        n_checks++;
        if (rd !== 32'h0000_0080 || lat != 2) begin
            n_fail++; $display("FAIL lbu: rdata=%h lat=%0d expected 00000080,2", rd, lat);
        end
    endtask

    task automatic test_halfword_store();
        logic rdy, err, ov; int lat, rd_at, wr_at; logic [31:0] wd, rd; logic [19:0] wa;
        set_word(1, 32'h1111_2222);
        do_req(1'b1, 32'h0200_0006, 2'd1, 1'b0, 32'h0000_ABCD, rdy, lat, rd_at, wr_at, wd, wa, rd, err, ov);
        model_store(32'h0200_0006, 2'd1, 32'h0000_ABCD);
        n_checks++;
        if (rd_at != 1 || wr_at != 2 || wd !== 32'hABCD_2222 || wa !== 20'h00004 || lat != 3 || err !== 1'b0 || ov) begin
            n_fail++;
            $display("FAIL sh_rmw: rd_at=%0d wr_at=%0d wdata=%h waddr=%h lat=%0d err=%b expected 1,2,abcd2222,00004,3,0",
                     rd_at, wr_at, wd, wa, lat, err);
        end
    endtask

    task automatic test_faults();
        logic rdy, err, ov; int lat, rd_at, wr_at; logic [31:0] wd, rd; logic [19:0] wa;
        do_req(1'b0, 32'h0200_0001, 2'd1, 1'b0, 32'h0, rdy, lat, rd_at, wr_at, wd, wa, rd, err, ov);
        n_checks++;
        if (lat != 1 || err !== 1'b1 || rd !== 32'h0 || rd_at != 0 || wr_at != 0) begin
            n_fail++; $display("FAIL fault_misaligned: lat=%0d err=%b rdata=%h rd_at=%0d wr_at=%0d expected 1,1,0,0,0",
                               lat, err, rd, rd_at, wr_at);
        end
`ifdef PERIPH_BUS_MASTER_ERR_CAPTURE_EN
        n_checks++;
        if (err_valid_o !== 1'b1 || err_addr_o !== 32'h0200_0001) begin
            n_fail++; $display("FAIL err_capture_first: valid=%b addr=%h expected 1,02000001", err_valid_o, err_addr_o);
        end
`endif
        do_req(1'b1, 32'h0300_0000, 2'd2, 1'b0, 32'hDEAD_BEEF, rdy, lat, rd_at, wr_at, wd, wa, rd, err, ov);
        n_checks++;
        if (lat != 1 || err !== 1'b1 || rd_at != 0 || wr_at != 0) begin
            n_fail++; $display("FAIL fault_region: lat=%0d err=%b rd_at=%0d wr_at=%0d expected 1,1,0,0",
                               lat, err, rd_at, wr_at);
        end
`ifdef PERIPH_BUS_MASTER_ERR_CAPTURE_EN
        n_checks++;
        if (err_valid_o !== 1'b1 || err_addr_o !== 32'h0200_0001) begin
            n_fail++; $display("FAIL err_capture_sticky: valid=%b addr=%h expected 1,02000001", err_valid_o, err_addr_o);
        end
        @(negedge clk_i); err_clr_i = 1'b1;
        @(posedge clk_i); #1; err_clr_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (err_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: valid=%b expected 0", err_valid_o);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic wr1, rdy1, rdy2, rdy3, wr2, rsp2;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h0200_0004; req_size_i = 2'd2;
        req_unsigned_i = 1'b0; req_wdata_i = 32'hFFFF_FFFF;
        @(posedge clk_i);
        @(negedge clk_i); wr1 = per_wr_en_o; rdy1 = req_ready_o;
        @(negedge clk_i); rdy2 = req_ready_o; rsp2 = rsp_valid_o;
        @(negedge clk_i); rdy3 = req_ready_o;
        @(negedge clk_i); wr2 = per_wr_en_o; req_valid_i = 1'b0;
        @(negedge clk_i);
        model_store(32'h0200_0004, 2'd2, 32'hFFFF_FFFF);
        n_checks++;
        if ({wr1, rdy1, rdy2, rsp2, rdy3, wr2} !== 6'b100111) begin
            n_fail++; $display("FAIL back_to_back: wr@T1=%b rdy@T1=%b rdy@T2=%b rsp@T2=%b rdy@T3=%b wr@T4=%b expected 100111",
                               wr1, rdy1, rdy2, rsp2, rdy3, wr2);
        end
    endtask

    task automatic test_reset_mid();
        logic wr_pre, wr_post, rd_post, rsp_post, rsp_seen;
        rsp_seen = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h0200_0006; req_size_i = 2'd1;
        req_wdata_i = 32'h0000_5555;
        @(posedge clk_i); #1; req_valid_i = 1'b0;
        @(posedge clk_i); #2;
        wr_pre = per_wr_en_o;
        rst_i = 1'b1; #1;
        wr_post = per_wr_en_o; rd_post = per_rd_en_o; rsp_post = rsp_valid_o;
        @(negedge clk_i); @(negedge clk_i); rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) rsp_seen = 1'b1;
        end
        n_checks++;
        if ({wr_pre, wr_post, rd_post, rsp_post, rsp_seen, req_ready_o} !== 6'b100001) begin
            n_fail++; $display("FAIL reset_mid_write: wr_pre=%b wr_post=%b rd_post=%b rsp_post=%b rsp_later=%b ready=%b expected 100001",
                               wr_pre, wr_post, rd_post, rsp_post, rsp_seen, req_ready_o);
        end
    endtask

    task automatic test_random();
        logic rdy, err, ov; int lat, rd_at, wr_at; logic [31:0] wd, rd; logic [19:0] wa;
        logic we, uns, f; logic [31:0] addr, wdata, exp_rd; logic [1:0] size; int exp_lat;
        for (int i = 0; i < 120; i++) begin
            addr = 32'h0200_0000 + $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) addr[31:20] = 12'h021 + 12'($urandom_range(0, 200));
            size = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0 && size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
            we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1)); wdata = $urandom;
            f = model_fault(addr, size);
            exp_lat = f ? 1 : ((we && size < 2'd2) ? 3 : 2);
            exp_rd = (f || we) ? 32'h0 : model_load(addr, size, uns);
            do_req(we, addr, size, uns, wdata, rdy, lat, rd_at, wr_at, wd, wa, rd, err, ov);
            n_checks++;
            if (!rdy || lat != exp_lat || err !== f || rd !== exp_rd || ov) begin
                n_fail++; $display("FAIL rand_rsp[%0d]: addr=%h sz=%0d we=%b lat=%0d err=%b rdata=%h expected lat=%0d err=%b rdata=%h",
                                   i, addr, size, we, lat, err, rd, exp_lat, f, exp_rd);
            end
            n_checks++;
            if (f ? (rd_at != 0 || wr_at != 0) :
                (we ? (wr_at != exp_lat - 1 || wa !== {addr[19:2], 2'b00} || rd_at != ((size < 2'd2) ? 1 : 0))
                    : (rd_at != 1 || wr_at != 0))) begin
                n_fail++; $display("FAIL rand_strobes[%0d]: addr=%h sz=%0d we=%b fault=%b rd_at=%0d wr_at=%0d waddr=%h",
                                   i, addr, size, we, f, rd_at, wr_at, wa);
            end
            if (!f && we) model_store(addr, size, wdata);
        end
    endtask

    initial begin
        test_reset();
        for (int w = 0; w < 64; w++) set_word(w, $urandom);
        test_word_load();
        test_byte_load();
        test_halfword_store();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
